// File: rtl/seq_overflow_accumulator_if.sv
// Handshake bundle between an operand source / result consumer and the
// overflow-detecting accumulator.
// Ports: master drives start, in_valid, in_data, out_ready and observes the
//   rest; slave (the accumulator) drives in_ready, out_valid, sum, count,
//   overflow, busy.
interface seq_overflow_accumulator_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 4,
  parameter int CNT_W   = $clog2(NUM_OPS + 1)
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             busy;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  in_ready, out_valid, sum, count, overflow, busy
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output in_ready, out_valid, sum, count, overflow, busy
  );
endinterface

// File: rtl/seq_overflow_accumulator.sv
// Sequential multi-operand adder: takes NUM_OPS unsigned operands one per
// handshake and reports the last partial sum that did not carry out of WIDTH.
// Latency: result valid the cycle after the last operand accept (start to
//   result minimum NUM_OPS+2 cycles). Backpressure: in_ready only in ACCUM,
//   in_valid low stalls; the result is held in DONE until out_ready.
// Ports: clk, rst (async, active-high), bus (seq_overflow_accumulator_if.slave).
// Optional build macro ACC_SATURATE_EN: when an overflow happened, sum reads
//   all-ones while the result is presented in DONE.
module seq_overflow_accumulator #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 4,
  parameter int CNT_W   = $clog2(NUM_OPS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  seq_overflow_accumulator_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(NUM_OPS - 1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;      // operands included in acc
  logic [CNT_W-1:0] op_cnt;   // operands accepted, including discarded ones
  logic             ovf;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [WIDTH:0]   t;
  logic             accept;

  // One extra bit captures the carry-out that marks an overflowing operand.
  assign t      = {1'b0, acc} + {1'b0, bus.in_data};
  assign accept = bus.in_valid && in_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      op_cnt      <= '0;
      ovf         <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc        <= '0;
            cnt        <= '0;
            op_cnt     <= '0;
            ovf        <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ACCUM;
          end
        end

        ACCUM: begin
          if (accept) begin
            // After the first overflow, operands are still consumed so the
            // source always delivers exactly NUM_OPS, but they are dropped.
            if (!ovf) begin
              if (t[WIDTH]) begin
                ovf <= 1'b1;
              end else begin
                acc <= t[WIDTH-1:0];
                cnt <= cnt + CNT_W'(1);
              end
            end
            op_cnt <= op_cnt + CNT_W'(1);
            if (op_cnt == LAST_OP) begin
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.count     = cnt;
  assign bus.overflow  = ovf;
  assign bus.busy      = busy_q;

`ifdef ACC_SATURATE_EN
  assign bus.sum = (ovf && (state == DONE)) ? {WIDTH{1'b1}} : acc;
`else
  assign bus.sum = acc;
`endif

endmodule

// File: tb/tb_seq_overflow_accumulator.sv
module tb_seq_overflow_accumulator;
  localparam int WIDTH   = 4;
  localparam int NUM_OPS = 4;
  localparam int CNT_W   = $clog2(NUM_OPS + 1);
  localparam int MAXV    = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  seq_overflow_accumulator_if #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .CNT_W(CNT_W)) bus ();

  seq_overflow_accumulator #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 collecting operands, 2 result presented.
  int m_phase = 0;
  int m_ops[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_ops.delete();
    end else begin
      case (m_phase)
        0: if (bus.start) begin m_ops.delete(); m_phase = 1; end
        1: if (bus.in_valid) begin
             m_ops.push_back(int'(bus.in_data));
             if (m_ops.size() == NUM_OPS) m_phase = 2;
           end
        default: if (bus.out_ready) m_phase = 0;
      endcase
    end
  end

  // Walk the collected operands with plain integer arithmetic.
  function automatic void model_result(output int s, output int c, output int o);
    int run = 0;
    c = 0;
    o = 0;
    foreach (m_ops[i]) begin
      if (o == 0) begin
        if (run + m_ops[i] > MAXV) o = 1;
        else begin run += m_ops[i]; c++; end
      end
    end
    s = run;
`ifdef ACC_SATURATE_EN
    if (o == 1 && m_phase == 2) s = MAXV;
`endif
  endfunction

  always @(negedge clk) begin
    int s, c, o;
    if (!rst) begin
      model_result(s, c, o);
      chk("in_ready",  int'(bus.in_ready),  int'(m_phase == 1));
      chk("out_valid", int'(bus.out_valid), int'(m_phase == 2));
      chk("busy",      int'(bus.busy),      int'(m_phase != 0));
      chk("sum",       int'(bus.sum),       s);
      chk("count",     int'(bus.count),     c);
      chk("overflow",  int'(bus.overflow),  o);
    end
  end

  // ---------------- stimulus ----------------
  int cur_ops[NUM_OPS];

  task automatic send_op(input int v);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = WIDTH'(v);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // exp_sum < 0 skips the literal checks (random runs rely on the model).
  task automatic run(input int gap, input int hold, input bit start_in_gap,
                     input int exp_sum, input int exp_cnt, input int exp_ovf);
    int n = 0;
    pulse_start();
    for (int i = 0; i < NUM_OPS; i++) begin
      send_op(cur_ops[i]);
      if (i < NUM_OPS - 1) begin
        for (int g = 0; g < gap; g++) begin
          bus.start = start_in_gap;
          @(negedge clk);
          bus.start = 1'b0;
        end
      end
    end
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("result_timeout", 0, 1);
    if (exp_sum >= 0) begin
      chk("lit_sum",      int'(bus.sum),      exp_sum);
      chk("lit_count",    int'(bus.count),    exp_cnt);
      chk("lit_overflow", int'(bus.overflow), exp_ovf);
      chk("lit_in_ready", int'(bus.in_ready), 0);
    end
    for (int h = 0; h < hold; h++) begin
      if (start_in_gap) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    if (exp_sum >= 0) chk("lit_out_valid_drop", int'(bus.out_valid), 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},  int'(bus.in_ready),  0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_sum"},       int'(bus.sum),       0);
    chk({tag, "_count"},     int'(bus.count),     0);
    chk({tag, "_overflow"},  int'(bus.overflow),  0);
    chk({tag, "_busy"},      int'(bus.busy),      0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    #3;
    check_reset_values("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    cur_ops = '{1, 2, 3, 4};
    run(0, 0, 1'b0, 10, 4, 0);

    cur_ops = '{5, 6, 7, 8};
`ifdef ACC_SATURATE_EN
    run(0, 0, 1'b0, 15, 2, 1);
`else
    run(0, 0, 1'b0, 11, 2, 1);
`endif

    cur_ops = '{15, 0, 1, 0};
    run(0, 0, 1'b0, 15, 2, 1);

    cur_ops = '{3, 3, 3, 3};
    run(2, 5, 1'b1, 12, 4, 0);

    // Asynchronous reset after two accepted operands.
    pulse_start();
    send_op(1);
    send_op(2);
    #2 rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    cur_ops = '{1, 1, 1, 1};
    run(0, 0, 1'b0, 4, 4, 0);

    // Randomized runs: mixed operand magnitudes, stalls and consumer delays.
    for (int r = 0; r < 150; r++) begin
      for (int i = 0; i < NUM_OPS; i++)
        cur_ops[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3)
                                                 : $urandom_range(0, MAXV);
      run($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
          -1, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
